cache_control: RTL
==================

CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4, number of ways driven by the one-hot way-load vector.
REQ-002 SHALL have parameter WAY_W, default 2, width of the way index; NUM_WAYS SHALL equal 2**WAY_W.
REQ-003 SHALL use one clock and a synchronous, active-high reset:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have the following CPU-side ports:
- mem_read  input  1  CPU read request; held until mem_resp.
- mem_write  input  1  CPU write request; held until mem_resp.
- mem_resp  output  1  one-cycle completion pulse.
REQ-005 SHALL have the following datapath-side ports:
- hit  input  1  tag match and valid in some way (current index).
- hit_way  input  WAY_W  way that hit; meaningful only when hit=1.
- victim_way  input  WAY_W  PLRU-selected replacement way.
- victim_dirty  input  1  dirty bit of victim_way.
- load_mem_rdata  output  1  selects hit-way data onto mem_rdata.
- way_load  output  NUM_WAYS  one-hot data/tag/valid write strobe, active-high; datapath inverts to the SRAM active-low web.
- dirty_set  output  1  set dirty bit of way_load way.
- dirty_clr  output  1  clear dirty bit of way_load way.
- data_sel  output  1  0 = CPU write data, 1 = pmem_rdata into data array.
- addr_sel  output  1  0 = CPU address, 1 = victim tag/index to pmem.
- plru_update  output  1  touch PLRU with the hit way.
REQ-006 SHALL have the following memory-side ports:
- pmem_read  output  1  line fill request.
- pmem_write  output  1  line writeback request.
- pmem_resp  input  1  memory completion, one-cycle pulse.

Function
REQ-007 SHALL implement FSM states IDLE, COMPARE, WRITEBACK, ALLOCATE.
REQ-008 IDLE: mem_read or mem_write high -> COMPARE next cycle; else stay. Entering COMPARE provides 1 cycle for SRAM read latency.
REQ-009 COMPARE with hit=1: mem_resp=1, plru_update=1, load_mem_rdata=1 on read; on write, way_load[hit_way]=1, data_sel=0, dirty_set=1; -> IDLE. Hit latency: 2 cycles from request to mem_resp.
REQ-010 COMPARE with hit=0: -> WRITEBACK if victim_dirty=1, else -> ALLOCATE; no outputs except hold.
REQ-011 WRITEBACK: pmem_write=1, addr_sel=1 every cycle until pmem_resp; on pmem_resp -> ALLOCATE, dirty_clr=1 for victim_way.
REQ-012 ALLOCATE: pmem_read=1, addr_sel=0 until pmem_resp; on pmem_resp assert way_load[victim_way]=1, data_sel=1, dirty_clr=1 for exactly that cycle, -> COMPARE (replay yields hit).
REQ-013 pmem_read and pmem_write SHALL never be high in the same cycle; way_load SHALL be zero or one-hot.
REQ-014 mem_read and mem_write both high SHALL be serviced as a write.
REQ-015 Request dropped while in WRITEBACK/ALLOCATE SHALL NOT abort the memory transaction; FSM completes it, then returns to IDLE from COMPARE without mem_resp.
REQ-016 pmem_resp outside WRITEBACK/ALLOCATE SHALL be ignored.

Reset
REQ-017 rst=1 SHALL force IDLE at the next edge, regardless of state, including mid-WRITEBACK/ALLOCATE.
REQ-018 During and after reset all outputs SHALL be 0 (way_load=0) until a new request.

Configuration
REQ-019 Macro CACHE_CTRL_PERF_EN SHALL add 32-bit outputs hit_count, miss_count, wb_count, which increment on COMPARE hit, COMPARE miss, and WRITEBACK completion respectively, saturate at 0xFFFFFFFF, and clear on rst.
REQ-020 Without CACHE_CTRL_PERF_EN, those ports and counters SHALL be absent; FSM behaviour SHALL be identical.

Structure
REQ-021 cache_types_pkg SHALL hold the FSM state enum, the NUM_WAYS/WAY_W defaults, and the addr_sel/data_sel encodings.
REQ-022 Counters SHALL reside in sub-module cache_perf_ctr, instantiated only under CACHE_CTRL_PERF_EN.

Verification
REQ-023 Read hit: mem_read=1, hit=1, hit_way=2 -> mem_resp and load_mem_rdata at cycle 2, plru_update=1, way_load=0.
REQ-024 Write hit: mem_write=1, hit=1, hit_way=1 -> way_load=4'b0010, dirty_set=1, mem_resp at cycle 2.
REQ-025 Clean miss: hit=0, victim_way=3, victim_dirty=0, pmem_resp after 5 cycles -> pmem_read for 5 cycles, way_load=4'b1000 with data_sel=1, then COMPARE hit, mem_resp.
REQ-026 Dirty miss: victim_dirty=1 -> pmem_write with addr_sel=1 until pmem_resp, then pmem_read, never overlapping.
REQ-027 rst asserted in the third ALLOCATE cycle -> next cycle IDLE, pmem_read=0, all outputs 0; with CACHE_CTRL_PERF_EN, counters read 0.

Source files
------------

// File: rtl/cache_types_pkg.sv
// Shared types for the cache controller: FSM state encoding, default geometry,
// and the address/data mux select encodings seen by the datapath.
package cache_types_pkg;

    localparam int DEF_NUM_WAYS = 4;
    localparam int DEF_WAY_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPARE   = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_ALLOCATE  = 2'd3
    } cache_state_e;

    localparam logic ADDR_SEL_CPU    = 1'b0;
    localparam logic ADDR_SEL_VICTIM = 1'b1;

    localparam logic DATA_SEL_CPU  = 1'b0;
    localparam logic DATA_SEL_PMEM = 1'b1;

    localparam logic [31:0] PERF_CTR_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/cache_perf_ctr.sv
// Saturating 32-bit event counters for hit, miss and writeback activity.
// Only instantiated when CACHE_CTRL_PERF_EN is defined.
module cache_perf_ctr
    import cache_types_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_hit,
    input  logic        inc_miss,
    input  logic        inc_wb,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] wb_count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (inc_hit && (hit_count != PERF_CTR_MAX))
                hit_count <= hit_count + 32'd1;
            if (inc_miss && (miss_count != PERF_CTR_MAX))
                miss_count <= miss_count + 32'd1;
            if (inc_wb && (wb_count != PERF_CTR_MAX))
                wb_count <= wb_count + 32'd1;
        end
    end

endmodule

// File: rtl/cache_control.sv
// Write-back, write-allocate cache controller FSM. Defining CACHE_CTRL_PERF_EN
// adds saturating hit/miss/writeback counters on extra output ports.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for a CPU request
//   COMPARE   | tag compare; hit completes, miss picks writeback/allocate
//   WRITEBACK | dirty victim line being written to physical memory
//   ALLOCATE  | line fill from physical memory, then replay the compare
module cache_control
    import cache_types_pkg::*;
#(
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int WAY_W    = DEF_WAY_W      // NUM_WAYS must equal 2**WAY_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                mem_write,
    output logic                mem_resp,
    input  logic                hit,
    input  logic [WAY_W-1:0]    hit_way,
    input  logic [WAY_W-1:0]    victim_way,
    input  logic                victim_dirty,
    output logic                load_mem_rdata,
    output logic [NUM_WAYS-1:0] way_load,
    output logic                dirty_set,
    output logic                dirty_clr,
    output logic                data_sel,
    output logic                addr_sel,
    output logic                plru_update,
    output logic                pmem_read,
    output logic                pmem_write,
`ifdef CACHE_CTRL_PERF_EN
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count,
    output logic [31:0]         wb_count,
`endif
    input  logic                pmem_resp
);

    cache_state_e state, state_next;
    logic         req_any;

    assign req_any = mem_read | mem_write;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next     = state;
        mem_resp       = 1'b0;
        load_mem_rdata = 1'b0;
        way_load       = '0;
        dirty_set      = 1'b0;
        dirty_clr      = 1'b0;
        data_sel       = DATA_SEL_CPU;
        addr_sel       = ADDR_SEL_CPU;
        plru_update    = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (req_any)
                    state_next = ST_COMPARE;
            end
            ST_COMPARE: begin
                // A request dropped during a fill is abandoned silently here.
                if (!req_any) begin
                    state_next = ST_IDLE;
                end else if (hit) begin
                    mem_resp    = 1'b1;
                    plru_update = 1'b1;
                    state_next  = ST_IDLE;
                    if (mem_write) begin
                        way_load[hit_way] = 1'b1;
                        data_sel          = DATA_SEL_CPU;
                        dirty_set         = 1'b1;
                    end else begin
                        load_mem_rdata = 1'b1;
                    end
                end else begin
                    state_next = victim_dirty ? ST_WRITEBACK : ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: begin
                pmem_write = 1'b1;
                addr_sel   = ADDR_SEL_VICTIM;
                if (pmem_resp) begin
                    dirty_clr  = 1'b1;
                    state_next = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                pmem_read = 1'b1;
                addr_sel  = ADDR_SEL_CPU;
                if (pmem_resp) begin
                    way_load[victim_way] = 1'b1;
                    data_sel             = DATA_SEL_PMEM;
                    dirty_clr            = 1'b1;
                    state_next           = ST_COMPARE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Outputs are held quiet for the whole reset cycle, even mid-transaction.
        if (rst) begin
            state_next     = ST_IDLE;
            mem_resp       = 1'b0;
            load_mem_rdata = 1'b0;
            way_load       = '0;
            dirty_set      = 1'b0;
            dirty_clr      = 1'b0;
            data_sel       = DATA_SEL_CPU;
            addr_sel       = ADDR_SEL_CPU;
            plru_update    = 1'b0;
            pmem_read      = 1'b0;
            pmem_write     = 1'b0;
        end
    end

`ifdef CACHE_CTRL_PERF_EN
    logic ev_hit, ev_miss, ev_wb;

    assign ev_hit  = (state == ST_COMPARE) && req_any && hit;
    assign ev_miss = (state == ST_COMPARE) && req_any && !hit;
    assign ev_wb   = (state == ST_WRITEBACK) && pmem_resp;

    cache_perf_ctr u_perf_ctr (
        .clk        (clk),
        .rst        (rst),
        .inc_hit    (ev_hit),
        .inc_miss   (ev_miss),
        .inc_wb     (ev_wb),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );
`endif

endmodule
